// File: rtl/bullet_pool.sv
// bullet_pool: multi-slot player projectile manager with aim, cooldown
// and per-slot kill, advanced once per video frame.
module bullet_pool #(
  parameter int          NUM_BULLETS = 4,
  parameter int          STEP        = 10,
  parameter int          SCROLL_STEP = 5,
  parameter int          COOLDOWN    = 6,
  parameter bit          AUTO_FIRE   = 1'b1,
  parameter logic [7:0]  FIRE_KEY    = 8'd44,
  parameter logic [9:0]  X_MAX       = 10'd639,
  parameter logic [9:0]  Y_MAX       = 10'd479,
  parameter logic [9:0]  PARK_Y      = 10'd485
) (
  input  logic                     frame_clk,
  input  logic                     Reset_n,
  input  logic [7:0]               keycode,
  input  logic                     fire_en,
  input  logic [9:0]               playerX,
  input  logic [9:0]               playerY,
  input  logic                     direction,
  input  logic [1:0]               aim,
  input  logic                     scroll,
  input  logic [NUM_BULLETS-1:0]   hit,
  output logic [10*NUM_BULLETS-1:0] BulletX,
  output logic [10*NUM_BULLETS-1:0] BulletY,
  output logic [NUM_BULLETS-1:0]   bactive,
  output logic                     fired
);

  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [9:0]    STEP_V = 10'(STEP);
  localparam logic [9:0]    SCR_V  = 10'(SCROLL_STEP);
  localparam logic [CW-1:0] CD_V   = CW'(COOLDOWN);

  logic [9:0] x_q  [NUM_BULLETS];
  logic [9:0] x_d  [NUM_BULLETS];
  logic [9:0] y_q  [NUM_BULLETS];
  logic [9:0] y_d  [NUM_BULLETS];
  logic [9:0] dx_q [NUM_BULLETS];
  logic [9:0] dx_d [NUM_BULLETS];
  logic [9:0] dy_q [NUM_BULLETS];
  logic [9:0] dy_d [NUM_BULLETS];

  logic [NUM_BULLETS-1:0] act_q, act_d;
  logic [NUM_BULLETS-1:0] free, spawn_vec;
  logic [CW-1:0]          cd_q, cd_d;
  logic                   held_q, held_d;
  logic                   fired_q, fired_d;
  logic                   fire_key, fire_ok;
  logic [9:0]             dx_new, dy_new, sc;

  always_comb begin
    fire_key  = (keycode == FIRE_KEY);
    free      = ~act_q;
    fire_ok   = fire_key && fire_en && (cd_q == '0)
              && (AUTO_FIRE || !held_q) && (|free);
    // one-hot of the lowest free slot, sampled before this edge's kills
    spawn_vec = fire_ok ? (free & (~free + NUM_BULLETS'(1))) : '0;
    sc        = scroll ? SCR_V : 10'd0;

    dx_new = direction ? STEP_V : (10'd0 - STEP_V);
    dy_new = 10'd0;
    unique case (aim)
      2'b01:   dy_new = 10'd0 - STEP_V;
      2'b10: begin
        dx_new = 10'd0;
        dy_new = 10'd0 - STEP_V;
      end
      default: ;
    endcase

    for (int i = 0; i < NUM_BULLETS; i++) begin
      x_d[i]   = playerX;
      y_d[i]   = PARK_Y;
      dx_d[i]  = 10'd0;
      dy_d[i]  = 10'd0;
      act_d[i] = 1'b0;
      if (spawn_vec[i]) begin
        act_d[i] = 1'b1;
        y_d[i]   = playerY;
        dx_d[i]  = dx_new;
        dy_d[i]  = dy_new;
      end else if (act_q[i] && !hit[i]
                   && x_q[i] <= X_MAX && y_q[i] <= Y_MAX) begin
        act_d[i] = 1'b1;
        x_d[i]   = x_q[i] + dx_q[i] - sc;
        y_d[i]   = y_q[i] + dy_q[i];
        dx_d[i]  = dx_q[i];
        dy_d[i]  = dy_q[i];
      end
    end

    cd_d = cd_q;
    unique case (1'b1)
      fire_ok:        cd_d = CD_V;
      (cd_q != '0):   cd_d = cd_q - CW'(1);
      default:        ;
    endcase

    fired_d = fire_ok;
    held_d  = fire_key;
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i]  <= 10'd0;
        y_q[i]  <= PARK_Y;
        dx_q[i] <= 10'd0;
        dy_q[i] <= 10'd0;
      end
      act_q   <= '0;
      cd_q    <= '0;
      held_q  <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i]  <= x_d[i];
        y_q[i]  <= y_d[i];
        dx_q[i] <= dx_d[i];
        dy_q[i] <= dy_d[i];
      end
      act_q   <= act_d;
      cd_q    <= cd_d;
      held_q  <= held_d;
      fired_q <= fired_d;
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_pack
    assign BulletX[10*g +: 10] = x_q[g];
    assign BulletY[10*g +: 10] = y_q[g];
  end

  assign bactive = act_q;
  assign fired   = fired_q;

endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: drives an auto-fire and a semi-auto bullet_pool in
// parallel and checks both against a frame-level reference model.
module tb_bullet_pool;

  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic [7:0] keycode;
  logic       fire_en;
  logic [9:0] playerX, playerY;
  logic       direction;
  logic [1:0] aim;
  logic       scroll;
  logic [3:0] hit;

  logic [39:0] bx [2];
  logic [39:0] by [2];
  logic [3:0]  ba [2];
  logic        fd [2];

  logic [39:0] ex [2];
  logic [39:0] ey [2];
  logic [3:0]  ea [2];
  logic        ef [2];

  int  mx [2][4];
  int  my [2][4];
  int  mdx [2][4];
  int  mdy [2][4];
  bit  mact [2][4];
  int  mcd [2];
  bit  mheld [2];
  bit  mfired [2];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 frame_clk = ~frame_clk;

  bullet_pool u_auto (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode),
    .fire_en(fire_en), .playerX(playerX), .playerY(playerY),
    .direction(direction), .aim(aim), .scroll(scroll), .hit(hit),
    .BulletX(bx[0]), .BulletY(by[0]), .bactive(ba[0]), .fired(fd[0])
  );

  bullet_pool #(.AUTO_FIRE(1'b0)) u_semi (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode),
    .fire_en(fire_en), .playerX(playerX), .playerY(playerY),
    .direction(direction), .aim(aim), .scroll(scroll), .hit(hit),
    .BulletX(bx[1]), .BulletY(by[1]), .bactive(ba[1]), .fired(fd[1])
  );

  function automatic int wrap10(int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  task automatic model_pack();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        ex[m][10*i +: 10] = 10'(mx[m][i]);
        ey[m][10*i +: 10] = 10'(my[m][i]);
        ea[m][i] = mact[m][i];
      end
      ef[m] = mfired[m];
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        mx[m][i] = 0; my[m][i] = 485;
        mdx[m][i] = 0; mdy[m][i] = 0;
        mact[m][i] = 0;
      end
      mcd[m] = 0; mheld[m] = 0; mfired[m] = 0;
    end
    model_pack();
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int sp = -1;
      bit want;
      want = (keycode == 8'd44) && fire_en && (mcd[m] == 0)
           && (m == 0 || !mheld[m]);
      if (want)
        for (int i = 0; i < 4; i++)
          if (!mact[m][i] && sp < 0) sp = i;
      for (int i = 0; i < 4; i++) begin
        if (i == sp) begin
          mact[m][i] = 1;
          mx[m][i] = playerX; my[m][i] = playerY;
          mdx[m][i] = (aim == 2) ? 0 : (direction ? 10 : -10);
          mdy[m][i] = (aim == 1 || aim == 2) ? -10 : 0;
        end else if (!mact[m][i] || hit[i]
                     || mx[m][i] > 639 || my[m][i] > 479) begin
          mact[m][i] = 0;
          mx[m][i] = playerX; my[m][i] = 485;
          mdx[m][i] = 0; mdy[m][i] = 0;
        end else begin
          mx[m][i] = wrap10(mx[m][i] + mdx[m][i] - (scroll ? 5 : 0));
          my[m][i] = wrap10(my[m][i] + mdy[m][i]);
        end
      end
      mcd[m] = (sp >= 0) ? 6 : ((mcd[m] > 0) ? mcd[m] - 1 : 0);
      mfired[m] = (sp >= 0);
      mheld[m] = (keycode == 8'd44);
    end
    model_pack();
  endtask

  task automatic tick();
    model_step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic idle_inputs();
    keycode = 8'd0; fire_en = 1'b1; playerX = 10'd0; playerY = 10'd0;
    direction = 1'b1; aim = 2'b00; scroll = 1'b0; hit = 4'd0;
  endtask

  task automatic do_reset();
    #2 Reset_n = 1'b0;
    #1 model_reset();
    #2 Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    playerX = 10'd50; playerY = 10'd400; keycode = 8'd44;
    for (int k = 0; k < 16; k++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if ({bx[m], by[m], ba[m], fd[m]} !== {ex[m], ey[m], ea[m], ef[m]}) begin
          n_fail++;
          $display("FAIL reset_pre inst%0d k%0d: got x=%h y=%h a=%b f=%b want x=%h y=%h a=%b f=%b",
                   m, k, bx[m], by[m], ba[m], fd[m], ex[m], ey[m], ea[m], ef[m]);
        end
      end
    end
    keycode = 8'd0;
    n_cmp++;
    if (ba[0] !== 4'b0111) begin
      n_fail++;
      $display("FAIL reset_three_active: got %b want 0111", ba[0]);
    end
    #2 Reset_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (ba[m] !== 4'd0 || by[m] !== {4{10'd485}} || fd[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_async inst%0d: got a=%b y=%h f=%b want a=0 y=%h f=0",
                 m, ba[m], by[m], fd[m], {4{10'd485}});
      end
    end
    model_reset();
    #2 Reset_n = 1'b1;
    playerX = 10'd77;
    tick();
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (bx[m] !== {4{10'd77}} || ba[m] !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_track inst%0d: got x=%h a=%b want x=%h a=0",
                 m, bx[m], ba[m], {4{10'd77}});
      end
    end
  endtask

  task automatic test_horizontal();
    idle_inputs();
    do_reset();
    playerX = 10'd100; playerY = 10'd300; keycode = 8'd44;
    tick();
    keycode = 8'd0;
    n_cmp++;
    if (ba[0][0] !== 1'b1 || bx[0][9:0] !== 10'd100
        || by[0][9:0] !== 10'd300 || fd[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL horiz_spawn: got a=%b x=%0d y=%0d f=%b want 1 100 300 1",
               ba[0][0], bx[0][9:0], by[0][9:0], fd[0]);
    end
    for (int k = 1; k <= 56; k++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if ({bx[m], by[m], ba[m], fd[m]} !== {ex[m], ey[m], ea[m], ef[m]}) begin
          n_fail++;
          $display("FAIL horiz inst%0d k%0d: got x=%h y=%h a=%b f=%b want x=%h y=%h a=%b f=%b",
                   m, k, bx[m], by[m], ba[m], fd[m], ex[m], ey[m], ea[m], ef[m]);
        end
      end
      if (k == 54) begin
        n_cmp++;
        if (bx[0][9:0] !== 10'd640 || ba[0][0] !== 1'b1) begin
          n_fail++;
          $display("FAIL horiz_edge: got x=%0d a=%b want 640 1", bx[0][9:0], ba[0][0]);
        end
      end
      if (k == 55) begin
        n_cmp++;
        if (ba[0][0] !== 1'b0 || by[0][9:0] !== 10'd485) begin
          n_fail++;
          $display("FAIL horiz_park: got a=%b y=%0d want 0 485", ba[0][0], by[0][9:0]);
        end
      end
    end
  endtask

  task automatic test_auto_fire();
    logic [19:0] fmask;
    idle_inputs();
    do_reset();
    fmask = '0;
    playerX = 10'd300; playerY = 10'd100; direction = 1'b0;
    keycode = 8'd44;
    for (int k = 0; k < 40; k++) begin
      if (k == 20) keycode = 8'd0;
      tick();
      if (k < 20) fmask[k] = fd[0];
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if ({bx[m], by[m], ba[m], fd[m]} !== {ex[m], ey[m], ea[m], ef[m]}) begin
          n_fail++;
          $display("FAIL auto inst%0d k%0d: got x=%h y=%h a=%b f=%b want x=%h y=%h a=%b f=%b",
                   m, k, bx[m], by[m], ba[m], fd[m], ex[m], ey[m], ea[m], ef[m]);
        end
      end
    end
    n_cmp++;
    if (fmask !== 20'h04081) begin
      n_fail++;
      $display("FAIL auto_spawn_frames: got %h want 04081", fmask);
    end
    n_cmp++;
    if (ba[0][0] !== 1'b0 || ba[0][2] !== 1'b1) begin
      n_fail++;
      $display("FAIL auto_wrap_park: got a=%b want slot0=0 slot2=1", ba[0]);
    end
  endtask

  task automatic test_semi_fire();
    int nf;
    idle_inputs();
    do_reset();
    nf = 0;
    playerX = 10'd600; playerY = 10'd100; direction = 1'b0;
    keycode = 8'd44;
    for (int k = 0; k < 22; k++) begin
      if (k == 20) keycode = 8'd0;
      if (k == 21) keycode = 8'd44;
      tick();
      if (k < 20) nf += int'(fd[1]);
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if ({bx[m], by[m], ba[m], fd[m]} !== {ex[m], ey[m], ea[m], ef[m]}) begin
          n_fail++;
          $display("FAIL semi inst%0d k%0d: got x=%h y=%h a=%b f=%b want x=%h y=%h a=%b f=%b",
                   m, k, bx[m], by[m], ba[m], fd[m], ex[m], ey[m], ea[m], ef[m]);
        end
      end
    end
    keycode = 8'd0;
    n_cmp++;
    if (nf !== 1) begin
      n_fail++;
      $display("FAIL semi_single: got %0d spawns want 1", nf);
    end
    n_cmp++;
    if (fd[1] !== 1'b1 || ba[1] !== 4'b0011 || bx[1][19:10] !== 10'd600) begin
      n_fail++;
      $display("FAIL semi_repress: got f=%b a=%b x1=%0d want 1 0011 600",
               fd[1], ba[1], bx[1][19:10]);
    end
  endtask

  task automatic test_aim();
    idle_inputs();
    do_reset();
    playerX = 10'd200; playerY = 10'd200; aim = 2'b01; scroll = 1'b1;
    keycode = 8'd44;
    tick();
    keycode = 8'd0;
    n_cmp++;
    if (bx[0][9:0] !== 10'd200 || by[0][9:0] !== 10'd200) begin
      n_fail++;
      $display("FAIL diag_spawn: got (%0d,%0d) want (200,200)", bx[0][9:0], by[0][9:0]);
    end
    tick();
    n_cmp++;
    if (bx[0][9:0] !== 10'd205 || by[0][9:0] !== 10'd190) begin
      n_fail++;
      $display("FAIL diag_move1: got (%0d,%0d) want (205,190)", bx[0][9:0], by[0][9:0]);
    end
    tick();
    n_cmp++;
    if (bx[0][9:0] !== 10'd210 || by[0][9:0] !== 10'd180) begin
      n_fail++;
      $display("FAIL diag_move2: got (%0d,%0d) want (210,180)", bx[0][9:0], by[0][9:0]);
    end
    idle_inputs();
    do_reset();
    playerX = 10'd200; playerY = 10'd40; aim = 2'b10; keycode = 8'd44;
    tick();
    keycode = 8'd0;
    aim = 2'b00; direction = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if ({bx[m], by[m], ba[m], fd[m]} !== {ex[m], ey[m], ea[m], ef[m]}) begin
          n_fail++;
          $display("FAIL up inst%0d k%0d: got x=%h y=%h a=%b f=%b want x=%h y=%h a=%b f=%b",
                   m, k, bx[m], by[m], ba[m], fd[m], ex[m], ey[m], ea[m], ef[m]);
        end
      end
      if (k == 5) begin
        n_cmp++;
        if (bx[0][9:0] !== 10'd200 || by[0][9:0] !== 10'd1014 || ba[0][0] !== 1'b1) begin
          n_fail++;
          $display("FAIL up_wrap: got x=%0d y=%0d a=%b want 200 1014 1",
                   bx[0][9:0], by[0][9:0], ba[0][0]);
        end
      end
      if (k == 6) begin
        n_cmp++;
        if (ba[0][0] !== 1'b0) begin
          n_fail++;
          $display("FAIL up_park: got a=%b want 0", ba[0][0]);
        end
      end
    end
  endtask

  task automatic test_full();
    idle_inputs();
    do_reset();
    playerX = 10'd0; playerY = 10'd50; keycode = 8'd44;
    for (int k = 0; k < 29; k++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if ({bx[m], by[m], ba[m], fd[m]} !== {ex[m], ey[m], ea[m], ef[m]}) begin
          n_fail++;
          $display("FAIL full inst%0d k%0d: got x=%h y=%h a=%b f=%b want x=%h y=%h a=%b f=%b",
                   m, k, bx[m], by[m], ba[m], fd[m], ex[m], ey[m], ea[m], ef[m]);
        end
      end
    end
    n_cmp++;
    if (ba[0] !== 4'hF || fd[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drop: got a=%b f=%b want 1111 0", ba[0], fd[0]);
    end
    hit = 4'b0100;
    tick();
    hit = 4'b0000;
    n_cmp++;
    if (ba[0] !== 4'b1011 || fd[0] !== 1'b0 || by[0][29:20] !== 10'd485) begin
      n_fail++;
      $display("FAIL full_hit: got a=%b f=%b y2=%0d want 1011 0 485",
               ba[0], fd[0], by[0][29:20]);
    end
    tick();
    n_cmp++;
    if (ba[0] !== 4'hF || fd[0] !== 1'b1 || bx[0][29:20] !== 10'd0) begin
      n_fail++;
      $display("FAIL full_reuse: got a=%b f=%b x2=%0d want 1111 1 0",
               ba[0], fd[0], bx[0][29:20]);
    end
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if ({bx[m], by[m], ba[m], fd[m]} !== {ex[m], ey[m], ea[m], ef[m]}) begin
        n_fail++;
        $display("FAIL full_model inst%0d: got x=%h y=%h a=%b f=%b want x=%h y=%h a=%b f=%b",
                 m, bx[m], by[m], ba[m], fd[m], ex[m], ey[m], ea[m], ef[m]);
      end
    end
  endtask

  task automatic test_random();
    idle_inputs();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      keycode   = ($urandom_range(0, 2) != 0) ? 8'd44 : 8'($urandom);
      fire_en   = ($urandom_range(0, 7) != 0);
      playerX   = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 639));
      playerY   = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 479));
      direction = 1'($urandom);
      aim       = 2'($urandom);
      scroll    = 1'($urandom);
      hit       = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if ({bx[m], by[m], ba[m], fd[m]} !== {ex[m], ey[m], ea[m], ef[m]}) begin
          n_fail++;
          $display("FAIL random inst%0d k%0d: got x=%h y=%h a=%b f=%b want x=%h y=%h a=%b f=%b",
                   m, k, bx[m], by[m], ba[m], fd[m], ex[m], ey[m], ea[m], ef[m]);
        end
      end
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #12 Reset_n = 1'b1;
    @(posedge frame_clk);
    #1;
    model_reset();
    do_reset();
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (ba[m] !== 4'd0 || bx[m] !== 40'd0 || by[m] !== {4{10'd485}} || fd[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: got x=%h y=%h a=%b f=%b want 0 %h 0 0",
                 m, bx[m], by[m], ba[m], fd[m], {4{10'd485}});
      end
    end
    test_reset();
    test_horizontal();
    test_auto_fire();
    test_semi_fire();
    test_aim();
    test_full();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
